data_mem_arbiter: RTL

Two-requester arbiter and sequencer for the byte-addressed data memory. It sits between the core load/store unit (port 0) and the DMA/debug loader (port 1) on one side and the single data memory instance on the other. It accepts one word request at a time via valid/ready, drives the memory enables for exactly one cycle, captures read data, and returns a one-cycle response to the owning requester. Misaligned requests are rejected without touching memory.

---
 rtl/data_mem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Brief    : Two-port word arbiter/sequencer for the data memory. Each request
//            takes three cycles: accept, memory access, then response.
//            Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie-break
//            (default: port 0 fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int ALIGN_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic              req_we_0,
    input  logic              req_we_1,
    input  logic [WORD_W-1:0] req_addr_0,
    input  logic [WORD_W-1:0] req_addr_1,
    input  logic [WORD_W-1:0] req_wdata_0,
    input  logic [WORD_W-1:0] req_wdata_1,
    output logic              resp_valid_0,
    output logic              resp_valid_1,
    output logic              resp_err,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_we;
    logic              r_owner;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_rdata;
    logic              r_err;
    logic              w_idle;
    logic              w_grant_1;
    logic              w_accept;
    logic              w_aligned;
    logic              w_mem_go;

    assign w_idle    = (r_state == S_IDLE);
    assign w_accept  = w_idle && !rst && (req_valid_0 || req_valid_1);
    assign w_aligned = (r_addr[ALIGN_BITS-1:0] == '0);
    assign w_mem_go  = (r_state == S_ACCESS) && w_aligned;

`ifdef ARB_ROUND_ROBIN_EN
    // Last-granted port; starts at 1 so port 0 wins the first tie.
    logic r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_grant_1;
        end
    end

    assign w_grant_1 = req_valid_1 && (!req_valid_0 || !r_last);
`else
    assign w_grant_1 = req_valid_1 && !req_valid_0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = S_ACCESS;
            S_ACCESS: w_state_next = S_RESP;
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Memory enables are deliberately not gated by rst: a write in ACCESS
    // commits on the same edge that samples reset.
    always_comb begin
        req_ready_0  = w_accept && !w_grant_1;
        req_ready_1  = w_accept && w_grant_1;
        resp_valid_0 = !rst && (r_state == S_RESP) && !r_owner;
        resp_valid_1 = !rst && (r_state == S_RESP) && r_owner;
        mem_read_en  = w_mem_go && !r_we;
        mem_write_en = w_mem_go && r_we;
        mem_addr     = w_mem_go ? r_addr  : '0;
        mem_wdata    = w_mem_go ? r_wdata : '0;
        busy         = !w_idle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_owner <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_owner <= w_grant_1;
            r_we    <= w_grant_1 ? req_we_1    : req_we_0;
            r_addr  <= w_grant_1 ? req_addr_1  : req_addr_0;
            r_wdata <= w_grant_1 ? req_wdata_1 : req_wdata_0;
        end else if (r_state == S_ACCESS) begin
            r_err   <= !w_aligned;
            r_rdata <= (w_aligned && !r_we) ? mem_rdata : '0;
        end
    end

    assign resp_err   = r_err;
    assign resp_rdata = r_rdata;
    assign owner      = r_owner;

endmodule
`default_nettype wire
